// File: rtl/writeback_stage.sv
// Y86 pipeline write-back stage: the M-to-W pipeline register, gating of the
// register-file write ports, and run/halt tracking.
// Optional build macro: WB_RETIRE_CNT_EN adds the retire_cnt output.

`ifndef NIBBLE
`define NIBBLE 3:0
`endif
`ifndef WORD
`define WORD 31:0
`endif
`ifndef NOREG
`define NOREG 4'hF
`endif

module writeback_stage #(
  parameter int STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [`NIBBLE]    m_icode,
  input  logic              m_cnd,
  input  logic [`NIBBLE]    m_dstE,
  input  logic [`NIBBLE]    m_dstM,
  input  logic [`WORD]      m_valE,
  input  logic [`WORD]      m_valM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [`NIBBLE]    w_dstE,
  output logic [`NIBBLE]    w_dstM,
  output logic [`WORD]      w_valE,
  output logic [`WORD]      w_valM,
  output logic [`NIBBLE]    W_icode,
  output logic [STAT_W-1:0] W_stat,
  output logic [STAT_W-1:0] cpu_stat,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  , output logic [`WORD]    retire_cnt
`endif
);

  localparam logic [STAT_W-1:0] STAT_BUB = STAT_W'(0);
  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);
  localparam logic [`NIBBLE]    I_NOP    = 4'h1;
  localparam logic [`NIBBLE]    I_RRMOVL = 4'h2;

  typedef enum logic {RUN, HALT} state_t;

  state_t       state;
  logic [`NIBBLE] W_dstE;
  logic [`NIBBLE] W_dstM;
  logic [`WORD]   W_valE;
  logic [`WORD]   W_valM;

  logic halt_now;
  logic hold;
  logic w_enable;

  // Detect a halting status in W (any code other than BUB/AOK, including 5-7)
  // and decide whether the W register holds this cycle.
  // The halting instruction is also frozen on the transition edge so that it
  // remains in W (and visible on cpu_stat) for the whole HALT period.
  always_comb begin
    halt_now = (state == RUN) && (W_stat != STAT_BUB) && (W_stat != STAT_AOK);
    hold     = (state == HALT) || halt_now || W_stall;
    w_enable = (state == RUN) && (W_stat == STAT_AOK);
  end

  // W pipeline register plus run/halt state machine with registered halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      W_stat  <= STAT_BUB;
      W_icode <= I_NOP;
      W_dstE  <= `NOREG;
      W_dstM  <= `NOREG;
      W_valE  <= '0;
      W_valM  <= '0;
      state   <= RUN;
      halted  <= 1'b0;
    end else begin
      if (!hold) begin
        if (W_bubble) begin
          W_stat  <= STAT_BUB;
          W_icode <= I_NOP;
          W_dstE  <= `NOREG;
          W_dstM  <= `NOREG;
          W_valE  <= '0;
          W_valM  <= '0;
        end else begin
          W_stat  <= m_stat;
          W_icode <= m_icode;
          W_dstE  <= (m_icode == I_RRMOVL && !m_cnd) ? `NOREG : m_dstE;
          W_dstM  <= m_dstM;
          W_valE  <= m_valE;
          W_valM  <= m_valM;
        end
      end
      if (halt_now) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

  // Register-file write ports and architectural status.
  always_comb begin
    w_dstE   = w_enable ? W_dstE : `NOREG;
    w_dstM   = w_enable ? W_dstM : `NOREG;
    w_valE   = W_valE;
    w_valM   = W_valM;
    cpu_stat = (W_stat == STAT_BUB) ? STAT_AOK : W_stat;
  end

`ifdef WB_RETIRE_CNT_EN
  // Count retiring instructions; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (w_enable && !W_stall) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [31:0] m_valE;
  logic [31:0] m_valM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [31:0] w_valE;
  logic [31:0] w_valM;
  logic [3:0]  W_icode;
  logic [2:0]  W_stat;
  logic [2:0]  cpu_stat;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rf [16];

  writeback_stage #(.STAT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_stat   (m_stat),
    .m_icode  (m_icode),
    .m_cnd    (m_cnd),
    .m_dstE   (m_dstE),
    .m_dstM   (m_dstM),
    .m_valE   (m_valE),
    .m_valM   (m_valM),
    .W_stall  (W_stall),
    .W_bubble (W_bubble),
    .w_dstE   (w_dstE),
    .w_dstM   (w_dstM),
    .w_valE   (w_valE),
    .w_valM   (w_valM),
    .W_icode  (W_icode),
    .W_stat   (W_stat),
    .cpu_stat (cpu_stat),
    .halted   (halted)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register file model: E port first, M port second so valM wins on a tie.
  always @(posedge clk) begin
    if (w_dstE != 4'hF) rf[w_dstE] <= w_valE;
    if (w_dstM != 4'hF) rf[w_dstM] <= w_valM;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [31:0] ve, input logic [31:0] vm);
    m_stat = st; m_icode = ic; m_cnd = cnd;
    m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    drive(3'd0, 4'h1, 1'b0, 4'hF, 4'hF, 32'h0, 32'h0);

    // Reset for two cycles
    step(); step();
    chk("rst_W_stat",   32'(W_stat),   32'd0);
    chk("rst_W_icode",  32'(W_icode),  32'h1);
    chk("rst_w_dstE",   32'(w_dstE),   32'hF);
    chk("rst_w_dstM",   32'(w_dstM),   32'hF);
    chk("rst_cpu_stat", 32'(cpu_stat), 32'd1);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_w_valE",   w_valE,        32'h0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire",   retire_cnt,    32'h0);
`endif
    rst = 1'b0;

    // OPL write to %ebx
    drive(3'd1, 4'h6, 1'b0, 4'h3, 4'hF, 32'h0000_1234, 32'h0);
    step();
    chk("opl_w_dstE",   32'(w_dstE),   32'h3);
    chk("opl_w_valE",   w_valE,        32'h1234);
    chk("opl_w_dstM",   32'(w_dstM),   32'hF);
    chk("opl_W_icode",  32'(W_icode),  32'h6);
    chk("opl_cpu_stat", 32'(cpu_stat), 32'd1);

    // cmov not taken, then taken
    drive(3'd1, 4'h2, 1'b0, 4'h1, 4'hF, 32'h55, 32'h0);
    step();
    chk("cmov0_w_dstE", 32'(w_dstE), 32'hF);
    chk("cmov0_w_valE", w_valE,      32'h55);
    chk("opl_commit",   rf[3],       32'h1234);
    drive(3'd1, 4'h2, 1'b1, 4'h1, 4'hF, 32'h66, 32'h0);
    step();
    chk("cmov1_w_dstE", 32'(w_dstE), 32'h1);

    // popl %esp: both ports target register 4
    drive(3'd1, 4'hB, 1'b0, 4'h4, 4'h4, 32'h100, 32'hBEEF);
    step();
    chk("popl_w_dstE", 32'(w_dstE), 32'h4);
    chk("popl_w_dstM", 32'(w_dstM), 32'h4);
    chk("popl_w_valM", w_valM,      32'hBEEF);
    drive(3'd0, 4'h1, 1'b0, 4'hF, 4'hF, 32'h0, 32'h0);
    step();
    chk("popl_commit", rf[4], 32'hBEEF);
    chk("idle_cpu_stat_bub", 32'(cpu_stat), 32'd1);

    // Stall beats bubble for three cycles, then bubble alone
    drive(3'd1, 4'h6, 1'b0, 4'h2, 4'hF, 32'h22, 32'h0);
    step();
    chk("ld_w_dstE", 32'(w_dstE), 32'h2);
    drive(3'd1, 4'h6, 1'b0, 4'h7, 4'hF, 32'h77, 32'h0);
    W_stall = 1'b1; W_bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_w_dstE", 32'(w_dstE), 32'h2);
      chk("stall_w_valE", w_valE,      32'h22);
    end
    W_stall = 1'b0;
    step();
    chk("bub_W_stat",   32'(W_stat),   32'd0);
    chk("bub_w_dstE",   32'(w_dstE),   32'hF);
    chk("bub_w_dstM",   32'(w_dstM),   32'hF);
    chk("bub_W_icode",  32'(W_icode),  32'h1);
    chk("bub_cpu_stat", 32'(cpu_stat), 32'd1);
    W_bubble = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    chk("retire_5", retire_cnt, 32'd5);
`endif

    // Halt followed by an AOK write to register 5
    drive(3'd2, 4'h0, 1'b0, 4'hF, 4'hF, 32'h0, 32'h0);
    step();
    chk("hlt_w_dstE",   32'(w_dstE),   32'hF);
    chk("hlt_cpu_stat", 32'(cpu_stat), 32'd2);
    chk("hlt_halted0",  32'(halted),   32'd0);
    drive(3'd1, 4'h6, 1'b0, 4'h5, 4'hF, 32'h5555, 32'h0);
    step();
    chk("hlt_halted1",  32'(halted),   32'd1);
    chk("hlt_cpu_stat1", 32'(cpu_stat), 32'd2);
    chk("hlt_w_dstE1",  32'(w_dstE),   32'hF);
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 4'h6, 1'b0, 4'h5, 4'h5, 32'h9000 + 32'(i), 32'h0);
      W_bubble = (i == 1);
      step();
      chk("halt_w_dstE",   32'(w_dstE),   32'hF);
      chk("halt_w_dstM",   32'(w_dstM),   32'hF);
      chk("halt_W_icode",  32'(W_icode),  32'h0);
      chk("halt_cpu_stat", 32'(cpu_stat), 32'd2);
      chk("halt_halted",   32'(halted),   32'd1);
    end
    W_bubble = 1'b0;
    chk("halt_no_commit", rf[5], 32'h0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_frozen", retire_cnt, 32'd5);
`endif

    // Reset clears HALT; ADR fault then halts
    rst = 1'b1;
    step();
    chk("rst2_halted",   32'(halted),   32'd0);
    chk("rst2_cpu_stat", 32'(cpu_stat), 32'd1);
    rst = 1'b0;
    drive(3'd3, 4'h5, 1'b0, 4'h6, 4'h6, 32'h11, 32'h22);
    step();
    chk("adr_w_dstE", 32'(w_dstE), 32'hF);
    chk("adr_w_dstM", 32'(w_dstM), 32'hF);
    drive(3'd1, 4'h6, 1'b0, 4'h5, 4'hF, 32'h1, 32'h0);
    step();
    chk("adr_halted",   32'(halted),   32'd1);
    chk("adr_cpu_stat", 32'(cpu_stat), 32'd3);

    // Unknown status code 5 halts, raw value reported
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(3'd5, 4'h6, 1'b0, 4'h2, 4'hF, 32'h1, 32'h0);
    step();
    chk("unk_w_dstE",   32'(w_dstE),   32'hF);
    chk("unk_halted0",  32'(halted),   32'd0);
    drive(3'd1, 4'h6, 1'b0, 4'h2, 4'hF, 32'h1, 32'h0);
    step();
    chk("unk_halted1",  32'(halted),   32'd1);
    chk("unk_cpu_stat", 32'(cpu_stat), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Y86 pipeline write-back stage: holds the M-to-W pipeline register and drives the register file write ports (dstE/valE, dstM/valM).
- Sits between the memory stage and the register file.
- Gates writes by instruction status.
- Tracks processor run/halt state.
- Reports the architectural status.

Parameters:
- STAT_W, 3, width of status code (BUB=0, AOK=1, HLT=2, ADR=3, INS=4)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- m_stat  in  STAT_W  status of instruction leaving memory stage
- m_icode  in  `NIBBLE  icode from memory stage
- m_cnd  in  1  condition flag (cmovXX) from memory stage
- m_dstE  in  `NIBBLE  E destination register, `NOREG if none
- m_dstM  in  `NIBBLE  M destination register, `NOREG if none
- m_valE  in  `WORD  ALU result
- m_valM  in  `WORD  memory read data
- W_stall  in  1  hold W register
- W_bubble  in  1  load bubble into W register
- w_dstE  out  `NIBBLE  to register file dstE
- w_dstM  out  `NIBBLE  to register file dstM
- w_valE  out  `WORD  to register file valE
- w_valM  out  `WORD  to register file valM
- W_icode  out  `NIBBLE  registered icode (for forwarding/control)
- W_stat  out  STAT_W  registered status
- cpu_stat  out  STAT_W  architectural status
- halted  out  1  processor stopped

Behaviour:
- Single clock domain. All state updates on posedge clk.
- rst is synchronous and active-high. It takes priority over all other inputs.
- W register fields: stat, icode, dstE, dstM, valE, valM.
- Reset/bubble value: stat=BUB, icode=NOP (4'h1), dstE=dstM=`NOREG, valE=valM=0.
- Load rule, in priority order:
  - rst → reset value.
  - state HALT → hold.
  - W_stall=1 → hold. Stall beats bubble if both are asserted.
  - W_bubble=1 → bubble value.
  - otherwise → capture m_* inputs.
- cmov gating at capture: if m_icode=RRMOVL (4'h2) and m_cnd=0, dstE is captured as `NOREG. All other fields are captured unchanged.
- Latency: m_* sampled at edge N appear on w_*/W_* after edge N. The register file commits them at edge N+1.
- Write gating is combinational from the W register:
  - w_dstE = W.dstE and w_dstM = W.dstM only when W_stat=AOK and state=RUN.
  - Otherwise both are `NOREG.
  - w_valE/w_valM always show W.valE/W.valM.
- dstE==dstM (e.g. popl %esp): both ports are driven. The register file's ordering makes valM win. No arbitration in this block.
- State machine:
  - RUN (reset state) → HALT on the edge after W_stat ∈ {HLT, ADR, INS} is observed while in RUN.
  - HALT is sticky until rst.
  - In HALT the W register is frozen and halted=1.
- halted is registered, reset 0. It asserts on the same edge as the transition to HALT.
- cpu_stat = AOK when W_stat=BUB; otherwise W_stat. Reset value AOK.
- The faulting/halting instruction never writes registers. Its dst outputs are `NOREG in the cycle it sits in W.
- Unknown stat codes (5–7) are treated as INS for halting purposes. cpu_stat still passes the raw value.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN
- Defined:
  - Adds output retire_cnt, `WORD, reset 0.
  - Increments by 1 on each edge where W_stat=AOK, state=RUN and W_stall=0 (one count per retired instruction).
  - Wraps 32'hFFFFFFFF → 0.
  - Holds in HALT.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → W_stat=BUB, w_dstE=w_dstM=4'hF, cpu_stat=AOK, halted=0.
- OPL write: m_stat=AOK, m_icode=6, m_dstE=3, m_valE=32'h0000_1234 → next cycle w_dstE=3, w_valE=32'h1234, w_dstM=4'hF.
- Untaken cmov: m_icode=2, m_cnd=0, m_dstE=1 → w_dstE=4'hF. Same with m_cnd=1 → w_dstE=1.
- popl %esp: m_dstE=4, m_dstM=4, valE=32'h100, valM=32'hBEEF → both ports drive 4. Register 4 reads 32'hBEEF after commit.
- Stall/bubble: load AOK dstE=2, then W_stall=1 and W_bubble=1 for 3 cycles → W register held. Then W_bubble alone → W_stat=BUB, dst `NOREG.
- Halt: m_stat=HLT followed by an AOK dstE=5 instruction:
  - w_dst stays 4'hF throughout.
  - cpu_stat=HLT, halted=1 from the next edge.
  - Later inputs ignored until rst.
  - With WB_RETIRE_CNT_EN, retire_cnt stops incrementing.
